// File: rtl/kmkz_dmem_arbiter.sv
// kmkz_dmem_arbiter: shares one data-memory port between the core load/store unit and an ext master
module kmkz_dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_wdata_i,
    input  logic [3:0]  c_sel_i,
    output logic        c_ack_o,
    output logic        c_err_o,
    output logic [31:0] c_rdata_o,
    input  logic        e_req_i,
    input  logic        e_we_i,
    input  logic [31:0] e_addr_i,
    input  logic [31:0] e_wdata_i,
    input  logic [3:0]  e_sel_i,
    output logic        e_ack_o,
    output logic        e_err_o,
    output logic [31:0] e_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_sel_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, CORE, EXT} state_t;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [3:0]  starve_q, starve_d;
    logic        busy, tmo_hit, done, core_win;

    // The core wins unless the ext master has waited through LIMIT core grants in a row
    assign core_win = c_req_i && !(e_req_i && starve_q == LIMIT);
    assign busy     = state_q != IDLE;
    assign tmo_hit  = busy && tmo_q == TMO_LAST;
    assign done     = busy && (mem_ready_i || tmo_hit);

    assign mem_req_o   = busy;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_sel_o   = mem_sel_q;

    // Completion is returned only to the owner; a ready in the timeout cycle still wins
    assign c_ack_o   = done && state_q == CORE;
    assign c_err_o   = c_ack_o && !mem_ready_i;
    assign c_rdata_o = (c_ack_o && mem_ready_i) ? mem_rdata_i : '0;
    assign e_ack_o   = done && state_q == EXT;
    assign e_err_o   = e_ack_o && !mem_ready_i;
    assign e_rdata_o = (e_ack_o && mem_ready_i) ? mem_rdata_i : '0;

    // Arbitration, grant capture, watchdog and starvation bookkeeping
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        tmo_d       = tmo_q;
        starve_d    = starve_q;
        if (state_q == IDLE) begin
            if (core_win) begin
                state_d     = CORE;
                mem_we_d    = c_we_i;
                mem_addr_d  = c_addr_i;
                mem_wdata_d = c_wdata_i;
                mem_sel_d   = c_sel_i;
                tmo_d       = '0;
                starve_d    = e_req_i ? starve_q + 4'd1 : '0;
            end else if (e_req_i) begin
                state_d     = EXT;
                mem_we_d    = e_we_i;
                mem_addr_d  = e_addr_i;
                mem_wdata_d = e_wdata_i;
                mem_sel_d   = e_sel_i;
                tmo_d       = '0;
                starve_d    = '0;
            end else begin
                starve_d    = '0;
            end
        end else begin
            tmo_d   = tmo_q + 8'd1;
            state_d = done ? IDLE : state_q;
        end
    end

    // State and captured request registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            tmo_q       <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            tmo_q       <= tmo_d;
            starve_q    <= starve_d;
        end
    end
endmodule
